simon_seq_ctrl: RTL and testbench

SIMON_SEQ_CTRL -- requirements
Module: simon_seq_ctrl

---
 rtl/simon_seq_ctrl.sv | 167 ++++++++++++++++
 tb/tb_simon_seq_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_seq_ctrl.sv
// ---------------------------------------------------------------------------
// simon_seq_ctrl
//   Game sequencer for a "Simon" style memory game. A start request captures
//   a 32-bit seed whose 2-bit fields are the colours of the pattern steps.
//   The pattern is then shown one step at a time, and the player has to
//   repeat it. Each correct full repetition grows the pattern by one step,
//   up to MAX_LEN steps.
//
// Parameters
//   MAX_LEN    final level (1..16)
//   ON_CYCLES  cycles each pattern step is lit (>=1)
//   OFF_CYCLES dark cycles after each pattern step (>=1)
//
// Ports
//   clk          clock, rising edge
//   reset        synchronous, active-high reset
//   start        one-cycle request to begin a new game
//   seed_in      seed from the seed generator
//   rst_seedgen  pulse, high in the cycle a start is accepted
//   btn_valid    player button press strobe
//   btn          colour of the pressed button
//   led_en       pattern LED lit
//   led_color    colour shown, 0 when dark
//   level        current sequence length, 0 when idle
//   busy         showing the pattern or waiting for input
//   win          game won
//   fail         game lost
// ---------------------------------------------------------------------------
module simon_seq_ctrl #(
   parameter int MAX_LEN    = 16,
   parameter int ON_CYCLES  = 4,
   parameter int OFF_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] seed_in,
   output logic        rst_seedgen,
   input  logic        btn_valid,
   input  logic [1:0]  btn,
   output logic        led_en,
   output logic [1:0]  led_color,
   output logic [4:0]  level,
   output logic        busy,
   output logic        win,
   output logic        fail
);

   localparam int TMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

   localparam logic [TW-1:0] ON_LOAD   = TW'(ON_CYCLES - 1);
   localparam logic [TW-1:0] OFF_LOAD  = TW'(OFF_CYCLES - 1);
   localparam logic [4:0]    MAX_LEN_L = 5'(MAX_LEN);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SHOW_ON,
      S_SHOW_OFF,
      S_INPUT,
      S_WIN,
      S_FAIL
   } state_t;

   state_t          state_q, state_d;
   logic [31:0]     seed_q, seed_d;
   logic [4:0]      level_q, level_d;
   logic [3:0]      idx_q, idx_d;
   logic [TW-1:0]   timer_q, timer_d;

   logic [1:0]      cur_col;
   logic            last_step;
   logic            start_ok;

   // Colour of the step currently pointed at by idx.
   assign cur_col   = seed_q[{idx_q, 1'b0} +: 2];
   assign last_step = ({1'b0, idx_q} == (level_q - 5'd1));
   assign start_ok  = start && ((state_q == S_IDLE) || (state_q == S_WIN) ||
                                (state_q == S_FAIL));

   // The only output not decoded from state: it marks the accepting cycle,
   // so it must also be suppressed when reset wins over start.
   assign rst_seedgen = start_ok && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         seed_q  <= '0;
         level_q <= '0;
         idx_q   <= '0;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         seed_q  <= seed_d;
         level_q <= level_d;
         idx_q   <= idx_d;
         timer_q <= timer_d;
      end
   end

   always_comb begin
      state_d = state_q;
      seed_d  = seed_q;
      level_d = level_q;
      idx_d   = idx_q;
      timer_d = timer_q;

      if (start_ok) begin
         seed_d  = seed_in;
         level_d = 5'd1;
         idx_d   = '0;
         timer_d = ON_LOAD;
         state_d = S_SHOW_ON;
      end else begin
         case (state_q)
            S_SHOW_ON: begin
               if (timer_q == '0) begin
                  timer_d = OFF_LOAD;
                  state_d = S_SHOW_OFF;
               end else begin
                  timer_d = timer_q - 1'b1;
               end
            end
            S_SHOW_OFF: begin
               if (timer_q == '0) begin
                  if (last_step) begin
                     idx_d   = '0;
                     state_d = S_INPUT;
                  end else begin
                     idx_d   = idx_q + 4'd1;
                     timer_d = ON_LOAD;
                     state_d = S_SHOW_ON;
                  end
               end else begin
                  timer_d = timer_q - 1'b1;
               end
            end
            S_INPUT: begin
               if (btn_valid) begin
                  if (btn != cur_col) begin
                     state_d = S_FAIL;
                  end else if (!last_step) begin
                     idx_d = idx_q + 4'd1;
                  end else if (level_q < MAX_LEN_L) begin
                     level_d = level_q + 5'd1;
                     idx_d   = '0;
                     timer_d = ON_LOAD;
                     state_d = S_SHOW_ON;
                  end else begin
                     state_d = S_WIN;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign led_en    = (state_q == S_SHOW_ON);
   assign led_color = led_en ? cur_col : 2'b00;
   assign level     = level_q;
   assign busy      = (state_q == S_SHOW_ON) || (state_q == S_SHOW_OFF) ||
                      (state_q == S_INPUT);
   assign win       = (state_q == S_WIN);
   assign fail      = (state_q == S_FAIL);

endmodule

// File: tb/tb_simon_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_simon_seq_ctrl
//   Bench for simon_seq_ctrl. A game-level reference model predicts every
//   cycle's outputs: a shown pattern is expanded into a queue of per-cycle
//   LED values, and player progress is tracked as level/position counters.
// ---------------------------------------------------------------------------
module tb_simon_seq_ctrl;

   localparam int ON   = 4;
   localparam int OFF  = 2;
   localparam int MAXL = 16;

   localparam int M_IDLE  = 0;
   localparam int M_SHOW  = 1;
   localparam int M_INPUT = 2;
   localparam int M_WIN   = 3;
   localparam int M_FAIL  = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] seed_in;
   logic        rst_seedgen;
   logic        btn_valid;
   logic [1:0]  btn;
   logic        led_en;
   logic [1:0]  led_color;
   logic [4:0]  level;
   logic        busy;
   logic        win;
   logic        fail;

   always #5 clk = ~clk;

   simon_seq_ctrl #(
      .MAX_LEN   (MAXL),
      .ON_CYCLES (ON),
      .OFF_CYCLES(OFF)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .seed_in    (seed_in),
      .rst_seedgen(rst_seedgen),
      .btn_valid  (btn_valid),
      .btn        (btn),
      .led_en     (led_en),
      .led_color  (led_color),
      .level      (level),
      .busy       (busy),
      .win        (win),
      .fail       (fail)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state.
   int          m_mode;
   logic [31:0] m_seed;
   int          m_level;
   int          m_idx;
   logic [2:0]  show_q[$];
   logic [11:0] last_got;

   typedef struct {
      logic       st;
      logic       bv;
      logic [1:0] b;
      logic       rs;
      logic [11:0] exp;
   } vec_t;
   vec_t tbl[$];

   function automatic logic [1:0] colour(input logic [31:0] s, input int i);
      return s[2*i +: 2];
   endfunction

   // {rst_seedgen, led_en, led_color, level, busy, win, fail}
   function automatic logic [11:0] pk(input logic rsg, input logic en,
                                      input logic [1:0] col, input int lvl,
                                      input logic bsy, input logic w,
                                      input logic f);
      return {rsg, en, col, 5'(lvl), bsy, w, f};
   endfunction

   function automatic logic [11:0] model_out(input logic st, input logic rs);
      logic rsg;
      logic [2:0] e;
      rsg = st && !rs && (m_mode == M_IDLE || m_mode == M_WIN || m_mode == M_FAIL);
      case (m_mode)
         M_SHOW: begin
            e = show_q[0];
            return pk(rsg, e[2], e[1:0], m_level, 1'b1, 1'b0, 1'b0);
         end
         M_INPUT: return pk(rsg, 1'b0, 2'b0, m_level, 1'b1, 1'b0, 1'b0);
         M_WIN:   return pk(rsg, 1'b0, 2'b0, m_level, 1'b0, 1'b1, 1'b0);
         M_FAIL:  return pk(rsg, 1'b0, 2'b0, m_level, 1'b0, 1'b0, 1'b1);
         default: return pk(rsg, 1'b0, 2'b0, 0, 1'b0, 1'b0, 1'b0);
      endcase
   endfunction

   task automatic build_show();
      show_q.delete();
      for (int i = 0; i < m_level; i++) begin
         repeat (ON) show_q.push_back({1'b1, colour(m_seed, i)});
         repeat (OFF) show_q.push_back(3'b000);
      end
   endtask

   task automatic model_reset();
      m_mode  = M_IDLE;
      m_seed  = '0;
      m_level = 0;
      m_idx   = 0;
      show_q.delete();
   endtask

   task automatic model_edge(input logic st, input logic bv, input logic [1:0] b,
                             input logic [31:0] sd, input logic rs);
      if (rs) begin
         model_reset();
      end else if (st && (m_mode == M_IDLE || m_mode == M_WIN || m_mode == M_FAIL)) begin
         m_seed  = sd;
         m_level = 1;
         m_idx   = 0;
         m_mode  = M_SHOW;
         build_show();
      end else if (m_mode == M_SHOW) begin
         void'(show_q.pop_front());
         if (show_q.size() == 0) begin
            m_mode = M_INPUT;
            m_idx  = 0;
         end
      end else if (m_mode == M_INPUT && bv) begin
         if (b != colour(m_seed, m_idx)) begin
            m_mode = M_FAIL;
         end else if (m_idx < m_level - 1) begin
            m_idx++;
         end else if (m_level < MAXL) begin
            m_level++;
            m_idx  = 0;
            m_mode = M_SHOW;
            build_show();
         end else begin
            m_mode = M_WIN;
         end
      end
   endtask

   task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got {rsg,en,col,lvl,busy,win,fail}=%b_%b_%b_%0d_%b%b%b want %b_%b_%b_%0d_%b%b%b",
                  tag, $time, got[11], got[10], got[9:8], got[7:3], got[2], got[1], got[0],
                  exp[11], exp[10], exp[9:8], exp[7:3], exp[2], exp[1], exp[0]);
      end
   endtask

   // One clock cycle: drive inputs, compare outputs against the model away
   // from the edge, then advance the model at the edge.
   task automatic cyc(input logic st, input logic bv, input logic [1:0] b,
                      input logic [31:0] sd, input logic rs, input string tag);
      logic [11:0] exp;
      start     = st;
      btn_valid = bv;
      btn       = b;
      seed_in   = sd;
      reset     = rs;
      @(negedge clk);
      last_got = {rst_seedgen, led_en, led_color, level, busy, win, fail};
      exp      = model_out(st, rs);
      check(tag, last_got, exp);
      @(posedge clk);
      model_edge(st, bv, b, sd, rs);
      #1;
   endtask

   task automatic idle(input string tag);
      cyc(1'b0, 1'b0, 2'b0, 32'h0, 1'b0, tag);
   endtask

   // Play correctly until the first show cycle of level tgt, or until WIN.
   task automatic play_to(input int tgt, input int budget, input string tag);
      bit reached;
      reached = 1'b0;
      for (int c = 0; c < budget; c++) begin
         if (m_mode == M_WIN ||
             (m_mode == M_SHOW && m_level == tgt && show_q.size() == tgt * (ON + OFF))) begin
            reached = 1'b1;
            break;
         end
         if (m_mode == M_INPUT)
            cyc(1'b0, 1'b1, colour(m_seed, m_idx), 32'h0, 1'b0, tag);
         else
            idle(tag);
      end
      n_checks++;
      if (!reached) begin
         n_errors++;
         $display("FAIL %s_timeout: goal not reached within %0d cycles (level=%0d)",
                  tag, budget, m_level);
      end
   endtask

   function automatic vec_t mk(input logic st, input logic bv, input logic [1:0] b,
                               input logic rs, input logic [11:0] exp);
      vec_t v;
      v.st = st; v.bv = bv; v.b = b; v.rs = rs; v.exp = exp;
      return v;
   endfunction

   initial begin
      start = 1'b0; btn_valid = 1'b0; btn = 2'b0; seed_in = '0; reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      model_reset();

      // Directed vectors: reset priority, first game at seed 0x1B.
      tbl.push_back(mk(1'b1, 1'b0, 2'd0, 1'b1, pk(0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, pk(0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(mk(1'b1, 1'b0, 2'd0, 1'b0, pk(1, 0, 0, 0, 0, 0, 0)));
      repeat (ON)  tbl.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, pk(0, 1, 3, 1, 1, 0, 0)));
      repeat (OFF) tbl.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, pk(0, 0, 0, 1, 1, 0, 0)));
      tbl.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, pk(0, 0, 0, 1, 1, 0, 0)));
      tbl.push_back(mk(1'b0, 1'b1, 2'd3, 1'b0, pk(0, 0, 0, 1, 1, 0, 0)));
      repeat (ON)  tbl.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, pk(0, 1, 3, 2, 1, 0, 0)));
      repeat (OFF) tbl.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, pk(0, 0, 0, 2, 1, 0, 0)));
      repeat (ON)  tbl.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, pk(0, 1, 2, 2, 1, 0, 0)));
      repeat (OFF) tbl.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, pk(0, 0, 0, 2, 1, 0, 0)));
      tbl.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, pk(0, 0, 0, 2, 1, 0, 0)));

      foreach (tbl[i]) begin
         cyc(tbl[i].st, tbl[i].bv, tbl[i].b, 32'h0000_001B, tbl[i].rs, "model_tbl");
         check($sformatf("vec%0d", i), last_got, tbl[i].exp);
      end

      // Level 2 at seed 0x1B: 3 is right, 1 is wrong (step 1 is colour 2).
      cyc(1'b0, 1'b1, 2'd3, 32'h0, 1'b0, "fail_seq");
      cyc(1'b0, 1'b1, 2'd1, 32'h0, 1'b0, "fail_seq");
      idle("fail_seq");
      check("fail_state", last_got, pk(0, 0, 0, 2, 0, 0, 1));
      idle("fail_hold");
      check("fail_hold", last_got, pk(0, 0, 0, 2, 0, 0, 1));

      // Restart from FAIL with a new seed; then presses and starts while busy.
      cyc(1'b1, 1'b0, 2'd0, 32'h0000_0002, 1'b0, "restart");
      check("restart_rsg", last_got, pk(1, 0, 0, 2, 0, 0, 1));
      idle("restart");
      check("restart_show", last_got, pk(0, 1, 2, 1, 1, 0, 0));
      for (int i = 0; i < ON + OFF - 1; i++)
         cyc(1'b1, 1'b1, 2'd2, 32'hFFFF_FFFF, 1'b0, "busy_ignore");
      idle("busy_ignore");
      check("busy_ignore_input", last_got, pk(0, 0, 0, 1, 1, 0, 0));
      cyc(1'b0, 1'b1, 2'd2, 32'h0, 1'b0, "busy_ignore");
      idle("busy_ignore");
      check("seed_kept", last_got, pk(0, 1, 2, 2, 1, 0, 0));

      // Full game to the win at seed 0.
      cyc(1'b0, 1'b0, 2'd0, 32'h0, 1'b1, "reset_mid");
      cyc(1'b1, 1'b0, 2'd0, 32'h0, 1'b0, "win_game");
      play_to(MAXL + 1, 2000, "win_game");
      idle("win_game");
      check("win_state", last_got, pk(0, 0, 0, 16, 0, 1, 0));

      // Restart from WIN, reset during the 2nd lit cycle of level 3.
      cyc(1'b1, 1'b0, 2'd0, 32'h0000_0024, 1'b0, "lvl3");
      play_to(3, 200, "lvl3");
      idle("lvl3_on1");
      cyc(1'b0, 1'b0, 2'd0, 32'h0, 1'b1, "lvl3_on2_reset");
      idle("post_reset");
      check("post_reset", last_got, pk(0, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < 8; i++) idle("post_reset_dark");

      // Random play against the model.
      for (int i = 0; i < 4000; i++) begin
         logic       st, bv, rs;
         logic [1:0] b;
         st = ($urandom % 40) == 0;
         bv = ($urandom % 3) == 0;
         b  = (($urandom % 5) != 0) ? colour(m_seed, m_idx) : 2'($urandom);
         rs = ($urandom % 600) == 0;
         cyc(st, bv, b, $urandom, rs, "random");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
